// File: rtl/ddr_rdata_tagger_if.sv
// Handshake bundle between the DDR read port, the read-command issue logic and
// the AXI-side data FIFO. The slave modport is the tagger; master is its environment.
interface ddr_rdata_tagger_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
);
  logic                  tag_valid;
  logic [ID_WIDTH-1:0]   tag_id;
  logic [3:0]            tag_len;
  logic                  tag_ready;
  logic                  ddr_rvalid;
  logic [DATA_WIDTH-1:0] ddr_rdata;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_id;
  logic                  out_last;
  logic                  out_ready;
  logic                  err_orphan;
  logic                  err_ovf;

  modport master (
    output tag_valid, tag_id, tag_len, ddr_rvalid, ddr_rdata, out_ready,
    input  tag_ready, out_valid, out_data, out_id, out_last, err_orphan, err_ovf
  );

  modport slave (
    input  tag_valid, tag_id, tag_len, ddr_rvalid, ddr_rdata, out_ready,
    output tag_ready, out_valid, out_data, out_id, out_last, err_orphan, err_ovf
  );
endinterface

// File: rtl/ddr_rdata_tagger.sv
// Tags unstallable DDR read beats with the ID/RLAST of their command and buffers
// them behind a credit scheme so every returning beat is guaranteed a slot.
module ddr_rdata_tagger #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int TAG_DEPTH  = 8,
  parameter int BUF_DEPTH  = 32
) (
  input  logic                  sclk,
  input  logic                  rst,
  ddr_rdata_tagger_if.slave     bus
);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int BAW = $clog2(BUF_DEPTH);
  localparam int CW  = BAW + 1;
  localparam logic [CW-1:0] BUF_FULL = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
  } beat_t;

  // Tag FIFO
  logic [ID_WIDTH-1:0] tag_id_mem  [TAG_DEPTH];
  logic [3:0]          tag_len_mem [TAG_DEPTH];
  logic [TAW:0]        tag_wr_q, tag_rd_q;
  logic                tag_empty, tag_full;

  // Beat buffer: memory FIFO behind a registered head entry
  beat_t               buf_mem [BUF_DEPTH];
  logic [BAW:0]        buf_wr_q, buf_rd_q;
  beat_t               head_q, head_d;
  logic                head_v_q, head_v_d;
  logic                mem_we, mem_re, mem_empty;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [CW-1:0]       credit_q, credit_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;
  logic                err_orphan_q, err_ovf_q;

  logic [CW-1:0]       len_beats;
  logic                tag_acc, beat_hit, beat_last, tag_pop;
  logic                buf_full, buf_push, buf_pop;
  logic [ID_WIDTH-1:0] head_id;
  logic [3:0]          head_len;
  beat_t               in_beat;

  assign tag_empty = (tag_wr_q == tag_rd_q);
  assign tag_full  = (tag_wr_q[TAW] != tag_rd_q[TAW]) &&
                     (tag_wr_q[TAW-1:0] == tag_rd_q[TAW-1:0]);
  assign head_id   = tag_id_mem[tag_rd_q[TAW-1:0]];
  assign head_len  = tag_len_mem[tag_rd_q[TAW-1:0]];

  assign len_beats     = CW'(bus.tag_len) + CW'(1);
  assign bus.tag_ready = ~tag_full & (credit_q >= len_beats);
  assign tag_acc       = bus.tag_valid & bus.tag_ready;

  // A beat with no outstanding tag is dropped; a beat into a full buffer still advances tagging
  assign beat_hit  = bus.ddr_rvalid & ~tag_empty;
  assign beat_last = (beat_cnt_q == head_len);
  assign tag_pop   = beat_hit & beat_last;
  assign in_beat   = '{data: bus.ddr_rdata, id: head_id, last: beat_last};

  assign mem_empty = (buf_wr_q == buf_rd_q);
  assign buf_full  = (cnt_q == BUF_FULL);
  assign buf_pop   = head_v_q & bus.out_ready;
  assign buf_push  = beat_hit & (~buf_full | buf_pop);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (!head_v_q || buf_pop) begin
      if (!mem_empty) begin
        head_d   = buf_mem[buf_rd_q[BAW-1:0]];
        head_v_d = 1'b1;
        mem_re   = 1'b1;
        mem_we   = buf_push;
      end else if (buf_push) begin
        head_d   = in_beat;
        head_v_d = 1'b1;
      end else begin
        head_v_d = 1'b0;
      end
    end else begin
      mem_we = buf_push;
    end
  end

  always_comb begin
    credit_d   = credit_q + CW'(buf_pop) - (tag_acc ? len_beats : '0);
    cnt_d      = cnt_q + CW'(buf_push) - CW'(buf_pop);
    beat_cnt_d = beat_cnt_q;
    if (beat_hit) beat_cnt_d = beat_last ? 4'd0 : beat_cnt_q + 4'd1;
  end

  // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge sclk) begin
    if (tag_acc) begin
      tag_id_mem[tag_wr_q[TAW-1:0]]  <= bus.tag_id;
      tag_len_mem[tag_wr_q[TAW-1:0]] <= bus.tag_len;
    end
    if (mem_we) buf_mem[buf_wr_q[BAW-1:0]] <= in_beat;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      buf_wr_q     <= '0;
      buf_rd_q     <= '0;
      head_q       <= '0;
      head_v_q     <= 1'b0;
      cnt_q        <= '0;
      credit_q     <= BUF_FULL;
      beat_cnt_q   <= '0;
      err_orphan_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      if (tag_acc) tag_wr_q <= tag_wr_q + 1'b1;
      if (tag_pop) tag_rd_q <= tag_rd_q + 1'b1;
      if (mem_we)  buf_wr_q <= buf_wr_q + 1'b1;
      if (mem_re)  buf_rd_q <= buf_rd_q + 1'b1;
      head_q       <= head_d;
      head_v_q     <= head_v_d;
      cnt_q        <= cnt_d;
      credit_q     <= credit_d;
      beat_cnt_q   <= beat_cnt_d;
      err_orphan_q <= err_orphan_q | (bus.ddr_rvalid & tag_empty);
      err_ovf_q    <= err_ovf_q | (beat_hit & buf_full & ~buf_pop);
    end
  end

  assign bus.out_valid  = head_v_q;
  assign bus.out_data   = head_q.data;
  assign bus.out_id     = head_q.id;
  assign bus.out_last   = head_q.last;
  assign bus.err_orphan = err_orphan_q;
  assign bus.err_ovf    = err_ovf_q;
endmodule
